fetch_queue: RTL

- Small in-order buffer between the instruction fetch unit and the decode/control stage of the MIPS core.
- Each entry holds one fetched instruction, its PC, and a predecode flag that marks control-transfer instructions.
- Decouples fetch from decode stalls through valid/ready handshakes on both sides.
- Discards every buffered entry on a redirect (taken branch/jump) so that wrong-path instructions never reach decode.

---
 rtl/mips_defs.sv | 29 ++
 rtl/fetch_queue_if.sv | 28 ++
 rtl/fetch_queue_ctrl_predecode.sv | 12 +
 rtl/fetch_queue.sv | 80 ++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared MIPS decode constants used by fetch, the fetch queue and control.
// Holds opcode/funct encodings, PC-source select codes and the control-transfer test.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_JR = 6'b001000;

  typedef enum logic [2:0] {
    PCSRC_ADD4 = 3'd0,
    PCSRC_JR   = 3'd1,
    PCSRC_BEQ  = 3'd2,
    PCSRC_BNE  = 3'd3,
    PCSRC_J    = 3'd4
  } pcsrc_e;

  function automatic logic is_ctrl_inst(input logic [31:0] inst);
    logic [5:0] opcode;
    logic [5:0] funct;
    opcode = inst[31:26];
    funct  = inst[5:0];
    return (opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_J) ||
           ((opcode == OP_RTYPE) && (funct == FUNCT_JR));
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch, the fetch queue and decode.
// slave = the queue itself, master = the fetch/decode environment driving it.
interface fetch_queue_if #(
  parameter int AW = 2
) ();

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_is_ctrl;
  logic [AW:0] count;

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_is_ctrl, count
  );

  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_is_ctrl, count
  );

endinterface

// File: rtl/fetch_queue_ctrl_predecode.sv
// Combinational predecode: flags beq, bne, j and jr so control can spot
// control-transfer instructions without a full decode.
module ctrl_predecode
  import mips_defs::*;
(
  input  logic [31:0] i_inst,
  output logic        o_is_ctrl
);

  assign o_is_ctrl = is_ctrl_inst(i_inst);

endmodule

// File: rtl/fetch_queue.sv
// In-order instruction buffer between fetch and decode with flush on redirect.
// Occupancy lives in r_count so full/empty never rely on pointer equality.
module fetch_queue
  import mips_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  fetch_queue_if.slave      bus
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

  logic [31:0]   r_pc_mem   [DEPTH];
  logic [31:0]   r_inst_mem [DEPTH];
  logic          r_ctrl_mem [DEPTH];

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_in_is_ctrl;

  ctrl_predecode u_predecode (
    .i_inst    (bus.in_inst),
    .o_is_ctrl (w_in_is_ctrl)
  );

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // rst gates the write enable so a push colliding with reset leaves storage untouched
  assign w_push = bus.in_valid && !w_full && !flush && rst;
  assign w_pop  = !w_empty && bus.out_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wptr]   <= bus.in_pc;
      r_inst_mem[r_wptr] <= bus.in_inst;
      r_ctrl_mem[r_wptr] <= w_in_is_ctrl;
    end
  end

  assign bus.in_ready    = !w_full;
  assign bus.out_valid   = !w_empty;
  assign bus.out_pc      = w_empty ? 32'h0 : r_pc_mem[r_rptr];
  assign bus.out_inst    = w_empty ? 32'h0 : r_inst_mem[r_rptr];
  assign bus.out_is_ctrl = w_empty ? 1'b0  : r_ctrl_mem[r_rptr];
  assign bus.count       = r_count;

endmodule
